// File: rtl/srl.sv
// WIDTH-bit synchronous set/reset storage cell with complementary outputs.
// Optional sticky S=R=1 flag on port `invalid` when SRL_INVALID_FLAG_EN is defined.
module srl #(
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned ILLEGAL_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar
`ifdef SRL_INVALID_FLAG_EN
    ,
    output logic             invalid
`endif
);

    logic [WIDTH-1:0] q_d, q_q;
    logic [WIDTH-1:0] set_only, clr_only, both;

    always_comb begin
        set_only = S & ~R;
        clr_only = R & ~S;
        both     = S & R;
        // Plain set/reset first; bits with S=R=1 are untouched here and resolved below.
        q_d      = (q_q & ~clr_only) | set_only;
        case (ILLEGAL_MODE)
            1:       q_d = q_d & ~both;
            2:       q_d = q_d | both;
            3:       q_d = q_d ^ both;
            default: q_d = q_d;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign Qbar = ~q_q;

`ifdef SRL_INVALID_FLAG_EN
    logic invalid_d, invalid_q;

    always_comb begin
        invalid_d = invalid_q | (|both);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            invalid_q <= 1'b0;
        end else begin
            invalid_q <= invalid_d;
        end
    end

    assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_srl.sv
// Self-checking bench for srl: directed table, 4-bit independence, random soak
// for every illegal-combination policy, and a master/slave pair on clk / ~clk.
`timescale 1ns/100ps
module tb_srl;

    logic clk = 1'b0;
    logic clk_n;
    always #5 clk = ~clk;
    assign clk_n = ~clk;

    logic       rst = 1'b1;
    logic       s1 = 1'b0, r1 = 1'b0;
    logic [3:0] q1, qb1, inv1;
    logic [3:0] s4 = '0, r4 = '0, q4, qb4;
    logic       inv4;
    logic       ms_s = 1'b0, ms_r = 1'b0;
    logic       mq, mqb, sq, sqb, minv, sinv;

    int n_cmp  = 0;
    int n_fail = 0;

    srl #(.WIDTH(1), .ILLEGAL_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1[0]), .Qbar(qb1[0])
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(inv1[0])
`endif
    );
    srl #(.WIDTH(1), .ILLEGAL_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1[1]), .Qbar(qb1[1])
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(inv1[1])
`endif
    );
    srl #(.WIDTH(1), .ILLEGAL_MODE(2)) u_m2 (
        .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1[2]), .Qbar(qb1[2])
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(inv1[2])
`endif
    );
    srl #(.WIDTH(1), .ILLEGAL_MODE(3)) u_m3 (
        .clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1[3]), .Qbar(qb1[3])
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(inv1[3])
`endif
    );
    srl #(.WIDTH(4), .ILLEGAL_MODE(3)) u_w4 (
        .clk(clk), .rst(rst), .S(s4), .R(r4), .Q(q4), .Qbar(qb4)
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(inv4)
`endif
    );
    srl #(.WIDTH(1), .ILLEGAL_MODE(3)) u_master (
        .clk(clk), .rst(rst), .S(ms_s), .R(ms_r), .Q(mq), .Qbar(mqb)
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(minv)
`endif
    );
    srl #(.WIDTH(1), .ILLEGAL_MODE(3)) u_slave (
        .clk(clk_n), .rst(rst), .S(mq), .R(mqb), .Q(sq), .Qbar(sqb)
`ifdef SRL_INVALID_FLAG_EN
        , .invalid(sinv)
`endif
    );

    // Reference behaviour of one SR cell, straight from the command truth table.
    function automatic logic ref_bit(input int unsigned mode, input logic q,
                                     input logic s, input logic r);
        if (!s && !r) return q;
        if (!s && r)  return 1'b0;
        if (s && !r)  return 1'b1;
        case (mode)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~q;
            default: return q;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic       s;
        logic       r;
        logic [3:0] exp_q;   // bit m = expected Q of the ILLEGAL_MODE=m cell
        logic       exp_inv;
    } vec_t;

    vec_t tbl[13];

    logic [3:0] ref1;
    logic [3:0] ref_inv1;
    logic [3:0] ref4;
    logic       ref_inv4;
    logic       mref;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 4'b0101, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 4'b1101, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 4'b0000, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0};

        // Directed table on the four single-bit cells.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = tbl[i].rst;
            s1  = tbl[i].s;
            r1  = tbl[i].r;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d_q", i), {4'b0, q1}, {4'b0, tbl[i].exp_q});
            check($sformatf("tbl%0d_qbar", i), {4'b0, qb1}, {4'b0, ~tbl[i].exp_q});
`ifdef SRL_INVALID_FLAG_EN
            check($sformatf("tbl%0d_inv", i), {4'b0, inv1}, {4'b0, {4{tbl[i].exp_inv}}});
`endif
        end

        // Multi-bit independence.
        @(negedge clk);
        rst = 1'b1; s4 = 4'b0000; r4 = 4'b0000;
        @(posedge clk); #1;
        check("w4_reset_q", {4'b0, q4}, 8'h00);
        @(negedge clk);
        rst = 1'b0; s4 = 4'b0101; r4 = 4'b0000;
        @(posedge clk); #1;
        check("w4_preload_q", {4'b0, q4}, 8'h05);
        @(negedge clk);
        s4 = 4'b1000; r4 = 4'b0001;
        @(posedge clk); #1;
        check("w4_mixed_q", {4'b0, q4}, 8'h0c);
        check("w4_mixed_qbar", {4'b0, qb4}, 8'h03);

        // Random soak of every policy against the reference model.
        ref1 = '0; ref_inv1 = '0; ref4 = '0; ref_inv4 = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            rst = (n == 0) || ($urandom_range(15) == 0);
            s1  = 1'($urandom_range(1));
            r1  = 1'($urandom_range(1));
            s4  = 4'($urandom);
            r4  = 4'($urandom);
            @(posedge clk);
            if (rst) begin
                ref1 = '0; ref_inv1 = '0; ref4 = '0; ref_inv4 = 1'b0;
            end else begin
                for (int m = 0; m < 4; m++) begin
                    ref1[m] = ref_bit(m, ref1[m], s1, r1);
                    ref_inv1[m] = ref_inv1[m] | (s1 & r1);
                end
                for (int b = 0; b < 4; b++) begin
                    ref4[b] = ref_bit(3, ref4[b], s4[b], r4[b]);
                    ref_inv4 = ref_inv4 | (s4[b] & r4[b]);
                end
            end
            #1;
            check($sformatf("rnd%0d_q1", n), {4'b0, q1}, {4'b0, ref1});
            check($sformatf("rnd%0d_qb1", n), {4'b0, qb1}, {4'b0, ~ref1});
            check($sformatf("rnd%0d_q4", n), {4'b0, q4}, {4'b0, ref4});
            check($sformatf("rnd%0d_qb4", n), {4'b0, qb4}, {4'b0, ~ref4});
`ifdef SRL_INVALID_FLAG_EN
            check($sformatf("rnd%0d_inv1", n), {4'b0, inv1}, {4'b0, ref_inv1});
            check($sformatf("rnd%0d_inv4", n), {7'b0, inv4}, {7'b0, ref_inv4});
`endif
        end

        // Master/slave pair with S/R changing every 7 ns, off the clock grid.
        @(negedge clk);
        rst = 1'b1; ms_s = 1'b1; ms_r = 1'b0;
        mref = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("ms_reset_master", {7'b0, mq}, 8'h00);
        #1 rst = 1'b0;
        fork
            begin
                #0.5;
                for (int k = 0; k < 10; k++) begin
                    ms_s = 1'($urandom_range(1));
                    ms_r = 1'($urandom_range(1));
                    #7;
                end
            end
            begin
                for (int c = 0; c < 8; c++) begin
                    @(posedge clk);
                    mref = ref_bit(3, mref, ms_s, ms_r);
                    #1;
                    check($sformatf("ms%0d_master", c), {7'b0, mq}, {7'b0, mref});
                    @(negedge clk);
                    #1;
                    check($sformatf("ms%0d_slave", c), {7'b0, sq}, {7'b0, mref});
                    check($sformatf("ms%0d_slave_bar", c), {7'b0, sqb}, {7'b0, ~mref});
                end
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/srl.md
Name: srl

Overview:
- `srl` is a clocked set/reset storage element, WIDTH bits wide, with complementary outputs.
- It is the basic cell for the SR flip-flop (`srff`) in the sequential-circuits library. `srff` chains two `srl` instances as master/slave, one on `clk` and one on `~clk`.
- Each bit updates once per rising clock edge from its S/R pair. The S=R=1 case is resolved by a parameterised policy.

Parameters:
- WIDTH, 1, number of independent SR cells; S, R, Q, Qbar are all WIDTH bits.
- ILLEGAL_MODE, 0, action on S=R=1: 0 = hold, 1 = reset-dominant, 2 = set-dominant, 3 = toggle.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- S  input  WIDTH  per-bit set request.
- R  input  WIDTH  per-bit reset request.
- Q  output  WIDTH  registered state.
- Qbar  output  WIDTH  bitwise complement of Q.
- Port order at instantiation: clk, rst, S, R, Q, Qbar.

Behaviour:
- All state changes occur on the rising edge of clk only. No combinational path from S/R to Q/Qbar.
- Reset:
  - rst=1 at a rising edge forces Q=0 and Qbar=all-ones on that edge.
  - rst has priority over S/R.
  - rst has no effect between edges, being synchronous.
- Per bit i, when rst=0 at a rising edge:
  - S=0, R=0: Q[i] holds.
  - S=0, R=1: Q[i] <= 0.
  - S=1, R=0: Q[i] <= 1.
  - S=1, R=1: per ILLEGAL_MODE:
    - 0: hold.
    - 1: Q[i] <= 0.
    - 2: Q[i] <= 1.
    - 3: Q[i] <= ~Q[i].
- Bits are fully independent; mixed commands across bits in one cycle are legal.
- Latency: one edge from S/R sampled to Q visible.
- Qbar is always exactly ~Q, including during and after reset. Q and Qbar are never equal, in any mode.
- Power-up state before the first reset is undefined; the bench applies rst before checking.
- Reset mid-sequence: the cycle with rst=1 discards S/R. The next edge with rst=0 acts on the then-current S/R normally.
- X/Z on S or R does not need to be handled; outputs may go X.
- ILLEGAL_MODE values outside 0..3 behave as 0.
- Synthesisable, edge-triggered flops only, no latches.
- Master/slave use: `srff` drives the second instance with ~clk. `srl` makes no assumption about clock duty cycle.

Optional Feature:
- Macro: SRL_INVALID_FLAG_EN.
- When defined:
  - Adds output port `invalid` (1 bit), placed after Qbar.
  - `invalid` is a registered, sticky flag. It is set on the first rising edge (rst=0) where any bit has S=R=1.
  - Only rst=1 clears it; reset value 0.
  - ILLEGAL_MODE still determines Q.
- When undefined:
  - The `invalid` port and its logic are absent.
  - Behaviour is otherwise identical.

Test Plan:
- Reset:
  - Hold rst=1 for 2 edges with S=1, R=0.
  - Required: Q=0, Qbar=1 after the first edge, and Q stays 0 while rst=1.
- Set/hold/reset (WIDTH=1):
  - After reset, apply S=1,R=0, then S=0,R=0 for 3 edges, then S=0,R=1.
  - Required: Q=1 one edge after the set and stays 1 through the hold edges; Q=0 one edge after the reset; Qbar=~Q throughout.
- Illegal combination, each ILLEGAL_MODE 0..3:
  - Preload Q=1, apply S=1,R=1 for 2 edges.
  - Required: mode 0 gives Q=1,1; mode 1 gives 0,0; mode 2 gives 1,1; mode 3 gives 0,1.
  - With SRL_INVALID_FLAG_EN: `invalid` reads 1 after the first S=R=1 edge and stays 1 until rst.
- Multi-bit independence (WIDTH=4):
  - From Q=4'b0101, apply S=4'b1000, R=4'b0001.
  - Required: Q=4'b1100 and Qbar=4'b0011 after one edge.
- Reset mid-operation:
  - With Q=1, assert rst=1 while S=1,R=0, then release rst.
  - Required: Q=0 on the rst edge and Q=1 on the following edge.
- Random soak plus master/slave:
  - Two `srl` instances chained on clk and ~clk, 10 ns clock period, S/R randomised every 7 ns for 10 changes, rst pulse first.
  - Required: the slave Q follows the master Q half a cycle later, and a reference model matches every edge.
